// File: rtl/chunked_lzc_sequencer.sv
// Multi-cycle leading-zero counter: scans one chunk per cycle from the MSB.
// Optional abort input enabled by defining CHUNKED_LZC_ABORT_EN.
module chunked_lzc_sequencer #(
    parameter int DATA_WIDTH  = 64,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
`ifdef CHUNKED_LZC_ABORT_EN
    input  logic                          abort,
`endif
    output logic [$clog2(DATA_WIDTH):0]   out_cnt,
    output logic                          out_zero
);

    localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
    localparam int CW         = $clog2(DATA_WIDTH) + 1;
    localparam int IW         = $clog2(NUM_CHUNKS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [CW-1:0]          acc_q, acc_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   zero_q, zero_d;
    logic                   abort_w;
    logic [CHUNK_WIDTH-1:0] slice;

`ifdef CHUNKED_LZC_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    function automatic logic [CW-1:0] slice_lz(input logic [CHUNK_WIDTH-1:0] s);
        logic [CW-1:0] n;
        logic          found;
        n     = '0;
        found = 1'b0;
        for (int i = CHUNK_WIDTH - 1; i >= 0; i--) begin
            if (!found) begin
                if (s[i]) found = 1'b1;
                else      n     = n + CW'(1);
            end
        end
        return n;
    endfunction

    // The captured word is shifted left on every zero chunk, so the
    // chunk under inspection always sits in the top bits.
    assign slice = data_q[DATA_WIDTH-1 -: CHUNK_WIDTH];

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && !abort_w) begin
                    data_d  = in_data;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (abort_w) begin
                    state_d = IDLE;
                end else if (slice != '0) begin
                    cnt_d   = acc_q + slice_lz(slice);
                    zero_d  = 1'b0;
                    state_d = DONE;
                end else if (idx_q == IW'(NUM_CHUNKS - 1)) begin
                    cnt_d   = CW'(DATA_WIDTH);
                    zero_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    acc_d   = acc_q + CW'(CHUNK_WIDTH);
                    idx_d   = idx_q + IW'(1);
                    data_d  = data_q << CHUNK_WIDTH;
                end
            end
            DONE: begin
                if (abort_w || out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !abort_w;
    assign out_valid = (state_q == DONE);
    assign out_cnt   = cnt_q;
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_chunked_lzc_sequencer.sv
// Randomised bench for chunked_lzc_sequencer (32-bit word, 8-bit chunks).
// Abort scenarios are exercised when CHUNKED_LZC_ABORT_EN is defined.
module tb_chunked_lzc_sequencer;

    localparam int DW  = 32;
    localparam int CHW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [5:0]    out_cnt;
    logic          out_zero;
`ifdef CHUNKED_LZC_ABORT_EN
    logic          abort = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    chunked_lzc_sequencer #(.DATA_WIDTH(DW), .CHUNK_WIDTH(CHW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef CHUNKED_LZC_ABORT_EN
        .abort     (abort),
`endif
        .out_cnt   (out_cnt),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Leading zeros counted bit by bit from the MSB.
    function automatic int ref_lz(input logic [DW-1:0] d);
        for (int i = DW - 1; i >= 0; i--)
            if (d[i]) return DW - 1 - i;
        return DW;
    endfunction

    // Number of chunks the scanner inspects before stopping.
    function automatic int ref_k(input logic [DW-1:0] d);
        int lz;
        lz = ref_lz(d);
        return (lz == DW) ? DW / CHW : lz / CHW + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic run_word(input logic [DW-1:0] d, input int stall);
        int cycles;
        logic [5:0] held;
        chk("idle_ready", 32'(in_ready), 32'd1);
        out_ready = (stall == 0);
        in_valid  = 1'b1;
        in_data   = d;
        tick();
        in_valid  = 1'b0;
        in_data   = $urandom;
        cycles    = 0;
        while (!out_valid && cycles < 10) begin
            chk("scan_ready", 32'(in_ready), 32'd0);
            tick();
            cycles++;
        end
        chk("latency", 32'(cycles), 32'(ref_k(d)));
        chk("valid", 32'(out_valid), 32'd1);
        chk("cnt", 32'(out_cnt), 32'(ref_lz(d)));
        chk("zero", 32'(out_zero), 32'(d == '0));
        if (cycles >= 10) begin
            do_reset();
            return;
        end
        held = out_cnt;
        if (stall > 0) begin
            for (int s = 1; s < stall; s++) begin
                tick();
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_cnt", 32'(out_cnt), 32'(held));
                chk("hold_ready", 32'(in_ready), 32'd0);
            end
            chk("done_ready", 32'(in_ready), 32'd0);
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_data   = $urandom;
        end
        tick();
        in_valid = 1'b0;
        chk("back_idle", 32'(in_ready), 32'd1);
        chk("drop_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        do_reset();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_cnt", 32'(out_cnt), 32'd0);
        chk("rst_zero", 32'(out_zero), 32'd0);

        run_word(32'h8000_0000, 0);
        run_word(32'h0000_0100, 0);
        run_word(32'h0000_0000, 0);
        run_word(32'h0001_FFFF, 3);
        run_word(32'h0000_00FF, 1);

        // reset while scanning an all-zero word
        in_valid = 1'b1;
        in_data  = '0;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_cnt", 32'(out_cnt), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mid_rst_quiet", 32'(out_valid), 32'd0);
        end
        run_word(32'h0000_0001, 0);

`ifdef CHUNKED_LZC_ABORT_EN
        in_valid = 1'b1;
        in_data  = '0;
        tick();
        in_valid = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        #1;
        chk("abort_idle", 32'(in_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("abort_quiet", 32'(out_valid), 32'd0);
            tick();
        end
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h0000_0010;
        #1;
        chk("abort_blocks", 32'(in_ready), 32'd0);
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("abort_nocap", 32'(in_ready), 32'd1);
        tick();
        chk("abort_novalid", 32'(out_valid), 32'd0);
        run_word(32'h0000_0010, 0);
`endif

        for (int n = 0; n < 40; n++) begin
            logic [DW-1:0] d;
            d = DW'($urandom) >> $urandom_range(0, DW);
            run_word(d, $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/chunked_lzc_sequencer.md
Name: chunked_lzc_sequencer

Overview:
Multi-cycle leading-zero counter for wide words. It scans the captured word one CHUNK_WIDTH slice per cycle, from the MSB slice downward, and stops at the first non-zero slice. It trades latency for a small per-cycle encoder, for use in normalisation paths where a full-width single-cycle count misses timing. Valid/ready handshakes sit on both sides.

Parameters:
- DATA_WIDTH, 64: width of the input word. Must be a multiple of CHUNK_WIDTH.
- CHUNK_WIDTH, 8: bits examined per scan cycle. Must be at least 1. NUM_CHUNKS = DATA_WIDTH/CHUNK_WIDTH, at least 2.

Ports:
- clk, input, 1: sole clock. All state updates on the rising edge.
- rst_n, input, 1: reset. Synchronous and active-low.
- in_valid, input, 1: a word is offered.
- in_ready, output, 1: the block can accept a word.
- in_data, input, DATA_WIDTH: word to count.
- out_valid, output, 1: result is available.
- out_ready, input, 1: consumer accepts the result.
- out_cnt, output, $clog2(DATA_WIDTH)+1: number of leading zeros, range 0..DATA_WIDTH.
- out_zero, output, 1: input word was all zeros (out_cnt == DATA_WIDTH).

Behaviour:
- Reset (rst_n low at an edge): state=IDLE, out_valid=0, out_cnt=0, out_zero=0, internal chunk index=0, captured word=0. Reset takes priority over every other event, including mid-SCAN and mid-DONE; any in-flight result is discarded.
- Outputs: in_ready is 1 only in IDLE (decoded from state). out_valid is 1 only in DONE. out_cnt and out_zero are registered and stable throughout DONE.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_valid=1 at an edge: capture in_data, set idx=0 (MSB slice) and acc=0, go to SCAN.
  - Otherwise stay in IDLE.
- SCAN (one slice per cycle, slice idx = bits [DATA_WIDTH-1-idx*CHUNK_WIDTH -: CHUNK_WIDTH]):
  - Slice non-zero: out_cnt = acc + leading zeros of the slice (0..CHUNK_WIDTH-1), out_zero=0, go to DONE.
  - Slice zero and idx < NUM_CHUNKS-1: acc += CHUNK_WIDTH, idx++, stay in SCAN.
  - Slice zero and idx == NUM_CHUNKS-1: out_cnt=DATA_WIDTH, out_zero=1, go to DONE.
- DONE:
  - Hold out_valid=1 and all results until out_ready=1 at an edge, then go to IDLE.
  - No back-to-back acceptance: in_ready stays 0 in DONE, even in the out_ready cycle.
- Latency: with acceptance at edge E, out_valid rises at edge E+k, where k = number of slices scanned (1..NUM_CHUNKS). Minimum throughput is one word per k+2 cycles.
- Arithmetic: acc and out_cnt are $clog2(DATA_WIDTH)+1 bits wide, so DATA_WIDTH is representable without overflow.
- in_data is sampled only at the acceptance edge. Changes to in_data after that edge have no effect.
- in_valid while not in IDLE is ignored. The upstream holds its word until in_ready.

Optional Feature:
- Macro: CHUNKED_LZC_ABORT_EN.
- Defined: adds input port abort (1 bit), placed after out_ready.
  - abort=1 at an edge in SCAN or DONE: go to IDLE, out_valid=0, result discarded.
  - In IDLE, abort=1 forces in_ready=0 for that cycle and no word is accepted.
  - rst_n still has priority over abort.
- Not defined: no abort port; behaviour exactly as above.

Test Plan (DATA_WIDTH=32, CHUNK_WIDTH=8, out_ready=1 unless stated):
- 32'h8000_0000 accepted at edge E -> out_valid at E+1 with out_cnt=0, out_zero=0; in_ready=1 again at E+2.
- 32'h0000_0100 -> three slices scanned; out_valid at E+3 with out_cnt=23, out_zero=0.
- 32'h0000_0000 -> out_valid at E+4 with out_cnt=32, out_zero=1.
- 32'h0001_FFFF, out_ready held low 3 cycles in DONE -> out_valid=1 and out_cnt=15 stable all 3 cycles; in_ready=0 throughout; IDLE the cycle after out_ready rises; a new in_valid in the DONE handshake cycle is not accepted.
- Reset mid-SCAN: accept 32'h0, drive rst_n=0 at E+2 -> the next cycle out_valid=0, in_ready=1, out_cnt=0; no result is produced. Then accept 32'h0000_0001 -> out_cnt=31.
- With CHUNKED_LZC_ABORT_EN: accept 32'h0, abort=1 at E+2 -> IDLE, out_valid never asserts. Then abort=1 with in_valid=1 in IDLE -> in_ready=0 and no capture.
